// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating direction counters plus a tagged
// target buffer, answering a fetch PC one cycle later and trained by execute.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            pred_req,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam logic [IDX_BITS-1:0] IDX_ONE = 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [IDX_BITS-1:0] clr_idx;

    logic [1:0]       ctr_tbl [ENTRIES];
    logic             bv_tbl  [ENTRIES];
    logic [TAG_W-1:0] tag_tbl [ENTRIES];
    logic [XLEN-1:0]  tgt_tbl [ENTRIES];

    logic [IDX_BITS-1:0] pred_idx_p0, upd_idx_p0;
    logic [TAG_W-1:0]    pred_tag_p0, upd_tag_p0;
    logic                pred_hit_p0;
    logic                unused_pc_bits;

    function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Stage p0: address split and table lookup on the request PC
    assign pred_idx_p0    = pred_pc[IDX_BITS+1:2];
    assign pred_tag_p0    = pred_pc[XLEN-1:IDX_BITS+2];
    assign upd_idx_p0     = upd_pc[IDX_BITS+1:2];
    assign upd_tag_p0     = upd_pc[XLEN-1:IDX_BITS+2];
    assign pred_hit_p0    = bv_tbl[pred_idx_p0] && (tag_tbl[pred_idx_p0] == pred_tag_p0);
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

    // Stage p1: registered prediction and init sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            clr_idx     <= '0;
            ready       <= 1'b0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            case (state)
                INIT: begin
                    pred_valid <= 1'b0;
                    pred_taken <= 1'b0;
                    clr_idx    <= clr_idx + IDX_ONE;
                    if (clr_idx == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    pred_valid <= pred_req;
                    pred_taken <= pred_req & pred_hit_p0 & ctr_tbl[pred_idx_p0][1];
                    if (pred_req)
                        pred_target <= pred_hit_p0 ? tgt_tbl[pred_idx_p0] : '0;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Table writes land at the edge, so a same-cycle lookup sees the old entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                ctr_tbl[clr_idx] <= 2'b01;
                bv_tbl[clr_idx]  <= 1'b0;
            end else if (upd_valid) begin
                ctr_tbl[upd_idx_p0] <= ctr_sat(ctr_tbl[upd_idx_p0], upd_taken);
                if (upd_taken) begin
                    bv_tbl[upd_idx_p0]  <= 1'b1;
                    tag_tbl[upd_idx_p0] <= upd_tag_p0;
                    tgt_tbl[upd_idx_p0] <= upd_target;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor (IDX_BITS=4): directed scenarios and random traffic
// compared every cycle against a table-level behavioural model.
module tb_branch_predictor;
    localparam int IB = 4;
    localparam int XL = 32;
    localparam int N  = 1 << IB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic          req = 1'b0;
    logic [XL-1:0] ppc = '0;
    logic          pred_valid, pred_taken;
    logic [XL-1:0] pred_target;
    logic          uv = 1'b0;
    logic [XL-1:0] upc = '0;
    logic          ut = 1'b0;
    logic [XL-1:0] utgt = '0;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    int            m_ctr [N];
    bit            m_bv  [N];
    logic [XL-1:0] m_tag [N];
    logic [XL-1:0] m_tgt [N];
    bit            m_ready = 0;
    int            m_cnt = 0;
    logic [XL-1:0] e_tgt = '0;

    branch_predictor #(.IDX_BITS(IB), .XLEN(XL)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pred_req(req), .pred_pc(ppc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(uv), .upd_pc(upc), .upd_taken(ut), .upd_target(utgt)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(logic [XL-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [XL-1:0] m_tagof(logic [XL-1:0] pc);
        return pc >> (IB + 2);
    endfunction

    task automatic chk(string tag, logic [XL-1:0] obs, logic [XL-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: derive expectations from the model, advance it, then compare.
    task automatic tick(string tag);
        int  i;
        bit  hit, ev, et;
        i   = m_idx(ppc);
        hit = m_bv[i] && (m_tag[i] == m_tagof(ppc));
        ev  = 0;
        et  = 0;
        if (rst) begin
            e_tgt = '0;
        end else if (m_ready && req) begin
            ev    = 1;
            et    = hit && (m_ctr[i] >= 2);
            e_tgt = hit ? m_tgt[i] : '0;
        end
        if (rst) begin
            m_cnt   = 0;
            m_ready = 0;
            for (int k = 0; k < N; k++) begin
                m_ctr[k] = 1;
                m_bv[k]  = 0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == N) m_ready = 1;
        end else if (uv) begin
            i = m_idx(upc);
            m_ctr[i] = ut ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                          : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
            if (ut) begin
                m_bv[i]  = 1;
                m_tag[i] = m_tagof(upc);
                m_tgt[i] = utgt;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_ready"}, {31'd0, ready}, {31'd0, m_ready});
        chk({tag, "_valid"}, {31'd0, pred_valid}, {31'd0, ev});
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({tag, "_target"}, pred_target, e_tgt);
    endtask

    task automatic do_reset(int ncyc);
        rst = 1'b1;
        for (int k = 0; k < ncyc; k++) tick("rst");
        rst  = 1'b0;
        req  = 1'b1;
        uv   = 1'b1;
        upc  = 32'h100;
        ut   = 1'b1;
        utgt = 32'h44;
        for (int k = 1; k <= N; k++) begin
            ppc = 32'h100 + 32'(k * 4);
            tick("init");
            chk("init_ready_edge", {31'd0, ready}, (k == N) ? 32'd1 : 32'd0);
            chk("init_no_pred", {31'd0, pred_valid}, 32'd0);
        end
        req = 1'b0;
        uv  = 1'b0;
    endtask

    task automatic predict(string tag, logic [XL-1:0] pc);
        req = 1'b1;
        ppc = pc;
        tick(tag);
        req = 1'b0;
    endtask

    task automatic update(string tag, logic [XL-1:0] pc, logic t, logic [XL-1:0] tgt);
        uv   = 1'b1;
        upc  = pc;
        ut   = t;
        utgt = tgt;
        tick(tag);
        uv = 1'b0;
    endtask

    initial begin
        // Reset and initialisation sweep
        do_reset(2);

        // Cold miss, then learn
        predict("t2a", 32'h100);
        chk("t2a_taken", {31'd0, pred_taken}, 32'd0);
        chk("t2a_valid", {31'd0, pred_valid}, 32'd1);
        update("t2b", 32'h100, 1'b1, 32'h80);
        predict("t2c", 32'h100);
        chk("t2c_taken", {31'd0, pred_taken}, 32'd1);
        chk("t2c_target", pred_target, 32'h80);

        // Saturation and hysteresis
        do_reset(1);
        for (int k = 0; k < 4; k++) update("t3_up", 32'h40, 1'b1, 32'h1000);
        update("t3_dn1", 32'h40, 1'b0, 32'h2222);
        predict("t3_p1", 32'h40);
        chk("t3_hyst_taken", {31'd0, pred_taken}, 32'd1);
        chk("t3_hyst_target", pred_target, 32'h1000);
        update("t3_dn2", 32'h40, 1'b0, 32'h0);
        predict("t3_p2", 32'h40);
        chk("t3_nt_taken", {31'd0, pred_taken}, 32'd0);
        for (int k = 0; k < 5; k++) update("t3_dn", 32'h40, 1'b0, 32'h0);
        update("t3_up1", 32'h40, 1'b1, 32'h1000);
        predict("t3_p3", 32'h40);
        chk("t3_floor_taken", {31'd0, pred_taken}, 32'd0);
        update("t3_up2", 32'h40, 1'b1, 32'h1000);
        predict("t3_p4", 32'h40);
        chk("t3_recover_taken", {31'd0, pred_taken}, 32'd1);

        // Tag alias at the same index
        do_reset(1);
        update("t4_train", 32'h100, 1'b1, 32'h80);
        predict("t4_alias", 32'h140);
        chk("t4_alias_taken", {31'd0, pred_taken}, 32'd0);
        chk("t4_alias_target", pred_target, 32'h0);

        // Same-cycle predict and update
        do_reset(1);
        update("t5_t", 32'h200, 1'b1, 32'h3000);
        update("t5_nt", 32'h200, 1'b0, 32'h0);
        req  = 1'b1;
        ppc  = 32'h200;
        uv   = 1'b1;
        upc  = 32'h200;
        ut   = 1'b1;
        utgt = 32'h3000;
        tick("t5_coll");
        req = 1'b0;
        uv  = 1'b0;
        chk("t5_coll_taken", {31'd0, pred_taken}, 32'd0);
        predict("t5_after", 32'h200);
        chk("t5_after_taken", {31'd0, pred_taken}, 32'd1);
        chk("t5_after_target", pred_target, 32'h3000);

        // Mid-run reset forgets all training
        for (int k = 1; k < 4; k++) begin
            update("t6_tr", 32'(32'h100 + k * 4), 1'b1, 32'(32'h500 + k));
            update("t6_tr", 32'(32'h100 + k * 4), 1'b1, 32'(32'h500 + k));
        end
        predict("t6_pre", 32'h104);
        chk("t6_pre_taken", {31'd0, pred_taken}, 32'd1);
        req = 1'b1;
        ppc = 32'h104;
        do_reset(1);
        for (int k = 1; k < 4; k++) begin
            predict("t6_post", 32'(32'h100 + k * 4));
            chk("t6_post_taken", {31'd0, pred_taken}, 32'd0);
        end

        // Random traffic over a few tags so hits, aliases and collisions occur
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 249) == 0);
            req  = $urandom_range(0, 1);
            ppc  = (32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, N - 1)) << 2)
                   | 32'($urandom_range(0, 3));
            uv   = $urandom_range(0, 1);
            upc  = (32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, N - 1)) << 2)
                   | 32'($urandom_range(0, 3));
            ut   = $urandom_range(0, 1);
            utgt = $urandom;
            tick("rnd");
        end
        rst = 1'b0;
        req = 1'b0;
        uv  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
